// File: rtl/fadc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fadc_pkg
//  Purpose  : Shared types and constants for the FADC capture path.
//             Provides the capture FSM state encoding, default bus widths,
//             the full-scale (saturation) code and buffer word layout.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package fadc_pkg;

  localparam int ADC_W  = 10;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  // Full-scale ADC code; a sample at this value is flagged as saturated.
  localparam logic [9:0] SAT_CODE = 10'h3FF;

  // Buffer word layout: {sat, zero pad, sample}.
  localparam int SAT_BIT = 15;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sat_cnt16.sv
`default_nettype none
// ============================================================================
//  Module   : sat_cnt16
//  Purpose  : 16-bit counter that sticks at all-ones instead of wrapping.
//  Ports    : clk   - clock, rising edge
//             rst   - synchronous active-high reset (clears count)
//             clr   - synchronous clear
//             inc   - add one this cycle (ignored once saturated)
//             count - current count
//  Revision : 1.0  initial release
// ============================================================================
module sat_cnt16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);
  import fadc_pkg::*;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fadc_capture.sv
`default_nettype none
// ============================================================================
//  Module   : fadc_capture
//  Purpose  : Writes one record of N_SAMPLES FADC samples into the sample
//             buffer after a launch and an optional programmable delay, then
//             holds the record until readout acknowledges it.
//  Ports    : CLK, RST     - clock / synchronous active-high reset
//             ENABLE       - capture enabled
//             LAUNCH       - launch request, one per high cycle
//             FADC_D       - ADC sample, valid every clock
//             DELAY        - clocks between launch and first sample
//             READ_DONE    - readout finished with the held record
//             wraddress    - buffer write address
//             data         - buffer write word {sat, 5'b0, sample}
//             wren         - buffer write enable
//             busy         - capture engine not idle
//             data_avail   - complete record held in the buffer
//             launch_lost  - saturating count of rejected launches
//  Revision : 1.0  initial release
// ============================================================================
module fadc_capture #(
  parameter int N_SAMPLES = 256,
  parameter int ADDR_W    = fadc_pkg::ADDR_W,
  parameter int ADC_W     = fadc_pkg::ADC_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ENABLE,
  input  logic              LAUNCH,
  input  logic [ADC_W-1:0]  FADC_D,
  input  logic [7:0]        DELAY,
  input  logic              READ_DONE,
  output logic [ADDR_W-1:0] wraddress,
  output logic [15:0]       data,
  output logic              wren,
  output logic              busy,
  output logic              data_avail,
  output logic [15:0]       launch_lost
);
  import fadc_pkg::*;

  // One extra bit so the write count can reach N_SAMPLES without wrapping.
  localparam int CNT_W = ADDR_W + 1;

  state_t             r_state, w_state_n;
  logic [7:0]         r_dcnt, w_dcnt_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n, w_slot;
  logic [ADDR_W-1:0]  w_addr_n;
  logic [15:0]        w_data_n, w_word;
  logic               w_wren_n, w_busy_n, w_avail_n;
  logic               w_emit, w_lost_inc;

  always_comb begin
    w_word          = '0;
    w_word[ADC_W-1:0] = FADC_D;
    w_word[SAT_BIT] = (FADC_D == ADC_W'(SAT_CODE));
  end

  always_comb begin
    w_state_n  = r_state;
    w_dcnt_n   = r_dcnt;
    w_cnt_n    = r_cnt;
    w_slot     = r_cnt;
    w_addr_n   = wraddress;
    w_data_n   = data;
    w_wren_n   = 1'b0;
    w_avail_n  = data_avail;
    w_emit     = 1'b0;
    w_lost_inc = LAUNCH && ENABLE && (r_state != ST_IDLE);

    case (r_state)
      ST_IDLE: begin
        if (ENABLE && LAUNCH) begin
          w_slot   = '0;
          w_cnt_n  = '0;
          w_addr_n = '0;
          if (DELAY == 8'd0) begin
            // Zero delay: the first write is issued on the launch edge.
            w_emit    = 1'b1;
            w_state_n = ST_CAPTURE;
          end else begin
            w_dcnt_n  = DELAY;
            w_state_n = ST_DELAY;
          end
        end
      end
      ST_DELAY: begin
        if (!ENABLE) begin
          w_state_n = ST_IDLE;
        end else begin
          w_dcnt_n = r_dcnt - 8'd1;
          if (r_dcnt == 8'd1) begin
            w_emit    = 1'b1;
            w_state_n = ST_CAPTURE;
          end
        end
      end
      ST_CAPTURE: begin
        if (!ENABLE) begin
          w_state_n = ST_IDLE;
        end else if (r_cnt == CNT_W'(N_SAMPLES)) begin
          w_state_n = ST_HOLD;
          w_avail_n = 1'b1;
        end else begin
          w_emit = 1'b1;
        end
      end
      ST_HOLD: begin
        if (READ_DONE) begin
          w_state_n = ST_IDLE;
          w_avail_n = 1'b0;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_avail_n = 1'b0;
      end
    endcase

    // w_slot is the index of the word being written on this edge.
    if (w_emit) begin
      w_wren_n = 1'b1;
      w_addr_n = w_slot[ADDR_W-1:0];
      w_data_n = w_word;
      w_cnt_n  = w_slot + CNT_W'(1);
    end

    w_busy_n = (w_state_n != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_dcnt     <= '0;
      r_cnt      <= '0;
      wraddress  <= '0;
      data       <= '0;
      wren       <= 1'b0;
      busy       <= 1'b0;
      data_avail <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_dcnt     <= w_dcnt_n;
      r_cnt      <= w_cnt_n;
      wraddress  <= w_addr_n;
      data       <= w_data_n;
      wren       <= w_wren_n;
      busy       <= w_busy_n;
      data_avail <= w_avail_n;
    end
  end

  sat_cnt16 u_lost_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (1'b0),
    .inc   (w_lost_inc),
    .count (launch_lost)
  );

endmodule
`default_nettype wire

// File: tb/tb_fadc_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fadc_capture
//  Purpose  : Self-checking bench for fadc_capture. Expected buffer writes
//             are queued when a launch is issued; a monitor pops and compares
//             each write the DUT presents.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_fadc_capture;

  localparam int SAT_CYC = 292;  // sample 7 of the capture launched at 280, DELAY=5

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ENABLE = 1'b0;
  logic        LAUNCH = 1'b0;
  logic [9:0]  FADC_D = 10'd0;
  logic [7:0]  DELAY = 8'd0;
  logic        READ_DONE = 1'b0;
  logic [7:0]  wraddress;
  logic [15:0] data;
  logic        wren;
  logic        busy;
  logic        data_avail;
  logic [15:0] launch_lost;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t q[$];

  fadc_capture #(.N_SAMPLES(256), .ADDR_W(8), .ADC_W(10)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ENABLE      (ENABLE),
    .LAUNCH      (LAUNCH),
    .FADC_D      (FADC_D),
    .DELAY       (DELAY),
    .READ_DONE   (READ_DONE),
    .wraddress   (wraddress),
    .data        (data),
    .wren        (wren),
    .busy        (busy),
    .data_avail  (data_avail),
    .launch_lost (launch_lost)
  );

  always #5 CLK = ~CLK;

  function automatic logic [9:0] adc_at(input int c);
    logic [31:0] cv;
    cv = c;
    return (c == SAT_CYC) ? 10'h3FF : cv[9:0];
  endfunction

  // Cycle counter; FADC_D carries the cycle index (or full scale at SAT_CYC).
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      cyc    = cyc + 1;
      FADC_D = adc_at(cyc);
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Launch accepted in cycle t: write k appears in cycle t+1+d+k with the
  // sample present in cycle t+d+k.
  task automatic push_record(input int t, input int d, input int n);
    exp_t       e;
    logic [9:0] v;
    logic [31:0] kv;
    for (int k = 0; k < n; k++) begin
      kv     = k;
      v      = adc_at(t + d + k);
      e.cyc  = t + 1 + d + k;
      e.addr = kv[7:0];
      e.data = {(v == 10'h3FF), 5'b00000, v};
      q.push_back(e);
    end
  endtask

  // Scoreboard monitor
  always @(negedge CLK) begin
    exp_t e;
    if (wren === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected @cycle %0d: addr=0x%0h data=0x%0h, no write expected",
                 cyc, wraddress, data);
      end else begin
        e = q.pop_front();
        if (wraddress !== e.addr || data !== e.data || cyc != e.cyc) begin
          failures++;
          $display("FAIL wr_word: got cycle=%0d addr=0x%0h data=0x%0h expected cycle=%0d addr=0x%0h data=0x%0h",
                   cyc, wraddress, data, e.cyc, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    // Reset
    go_to(3);
    chk("rst_wraddress", {24'd0, wraddress}, 32'd0);
    chk("rst_data", {16'd0, data}, 32'd0);
    chk("rst_wren", {31'd0, wren}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_data_avail", {31'd0, data_avail}, 32'd0);
    chk("rst_launch_lost", {16'd0, launch_lost}, 32'd0);
    go_to(4);
    RST    = 1'b0;
    ENABLE = 1'b1;

    // Zero-delay full record
    go_to(10);
    DELAY  = 8'd0;
    LAUNCH = 1'b1;
    push_record(10, 0, 256);
    step();
    LAUNCH = 1'b0;
    chk("t1_busy_after_launch", {31'd0, busy}, 32'd1);
    go_to(266);
    chk("t1_wren_last", {31'd0, wren}, 32'd1);
    chk("t1_avail_before_end", {31'd0, data_avail}, 32'd0);
    go_to(267);
    chk("t1_wren_fall", {31'd0, wren}, 32'd0);
    chk("t1_avail_rise", {31'd0, data_avail}, 32'd1);
    chk("t1_addr_hold", {24'd0, wraddress}, 32'd255);

    // Launches in HOLD are lost, then readout releases the record
    go_to(270); LAUNCH = 1'b1;
    go_to(271); LAUNCH = 1'b0;
    go_to(272); LAUNCH = 1'b1;
    go_to(273); LAUNCH = 1'b0;
    go_to(274); LAUNCH = 1'b1;
    go_to(275); LAUNCH = 1'b0;
    chk("t3_lost_3", {16'd0, launch_lost}, 32'd3);
    go_to(276); READ_DONE = 1'b1;
    go_to(277); READ_DONE = 1'b0;
    chk("t3_avail_fall", {31'd0, data_avail}, 32'd0);
    chk("t3_busy_fall", {31'd0, busy}, 32'd0);

    // DELAY=5, saturated sample at write 7, DELAY changed after acceptance
    go_to(280);
    DELAY  = 8'd5;
    LAUNCH = 1'b1;
    push_record(280, 5, 256);
    step();
    LAUNCH = 1'b0;
    DELAY  = 8'd200;
    chk("t2_busy_in_delay", {31'd0, busy}, 32'd1);
    go_to(285);
    chk("t2_no_early_write", {31'd0, wren}, 32'd0);
    go_to(293);
    chk("t4_sat_addr", {24'd0, wraddress}, 32'd7);
    chk("t4_sat_data", {16'd0, data}, 32'h0000_83FF);
    go_to(542);
    chk("t2_avail", {31'd0, data_avail}, 32'd1);
    chk("t2_addr_no_wrap", {24'd0, wraddress}, 32'd255);

    // LAUNCH together with READ_DONE: counted lost, module back in IDLE
    go_to(545);
    LAUNCH    = 1'b1;
    READ_DONE = 1'b1;
    step();
    LAUNCH    = 1'b0;
    READ_DONE = 1'b0;
    chk("t3_coincide_busy", {31'd0, busy}, 32'd0);
    chk("t3_coincide_lost", {16'd0, launch_lost}, 32'd4);

    // Launch while disabled in IDLE: ignored and not counted
    ENABLE = 1'b0;
    LAUNCH = 1'b1;
    step();
    LAUNCH = 1'b0;
    ENABLE = 1'b1;
    chk("dis_busy", {31'd0, busy}, 32'd0);
    chk("dis_lost", {16'd0, launch_lost}, 32'd4);

    // Abort by dropping ENABLE during write 100
    go_to(548);
    DELAY  = 8'd0;
    LAUNCH = 1'b1;
    push_record(548, 0, 101);
    step();
    LAUNCH = 1'b0;
    go_to(649);
    ENABLE = 1'b0;
    step();
    ENABLE = 1'b1;
    chk("t5_wren", {31'd0, wren}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_avail", {31'd0, data_avail}, 32'd0);
    chk("t5_lost", {16'd0, launch_lost}, 32'd4);

    // Full record, ENABLE dropped in HOLD keeps it, then saturate the count
    go_to(652);
    LAUNCH = 1'b1;
    push_record(652, 0, 256);
    step();
    LAUNCH = 1'b0;
    go_to(910);
    ENABLE = 1'b0;
    step();
    ENABLE = 1'b1;
    chk("hold_enable_drop_avail", {31'd0, data_avail}, 32'd1);
    chk("hold_enable_drop_busy", {31'd0, busy}, 32'd1);
    go_to(912);
    LAUNCH = 1'b1;
    go_to(66442);
    chk("t6_lost_fffe", {16'd0, launch_lost}, 32'h0000_FFFE);
    go_to(66450);
    chk("t6_lost_sat", {16'd0, launch_lost}, 32'h0000_FFFF);
    LAUNCH = 1'b0;
    go_to(66452);
    READ_DONE = 1'b1;
    step();
    READ_DONE = 1'b0;
    LAUNCH    = 1'b1;
    push_record(66453, 0, 6);
    step();
    LAUNCH = 1'b0;

    // Reset in the middle of a capture
    go_to(66459);
    chk("t6_precap_wren", {31'd0, wren}, 32'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("t6_rst_wraddress", {24'd0, wraddress}, 32'd0);
    chk("t6_rst_data", {16'd0, data}, 32'd0);
    chk("t6_rst_wren", {31'd0, wren}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_avail", {31'd0, data_avail}, 32'd0);
    chk("t6_rst_lost", {16'd0, launch_lost}, 32'd0);

    go_to(66470);
    chk("sb_all_writes_seen", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
